// File: rtl/oam_scanner_if.sv
// Scanner-to-parent bundle: OAM read port, scan control/status and buffer read port.
// The master side is the scanner; the slave side is the PPU parent and renderer.
interface oam_scanner_if;
    logic        start;
    logic [7:0]  ly;
    logic        obj_size;
    logic        obj_ena;
    logic [6:0]  oam_addr;
    logic [15:0] oam_data;
    logic        busy;
    logic        done;
    logic [3:0]  count;
    logic [3:0]  rd_idx;
    logic        rd_valid;
    logic [7:0]  rd_x;
    logic [3:0]  rd_row;
    logic [7:0]  rd_tile;
    logic [7:0]  rd_attr;

    modport master (
        input  start, ly, obj_size, obj_ena, oam_data, rd_idx,
        output oam_addr, busy, done, count, rd_valid, rd_x, rd_row, rd_tile, rd_attr
    );

    modport slave (
        output start, ly, obj_size, obj_ena, oam_data, rd_idx,
        input  oam_addr, busy, done, count, rd_valid, rd_x, rd_row, rd_tile, rd_attr
    );
endinterface

// File: rtl/oam_scanner.sv
// Mode-2 OAM scan: 2 dots per entry, 80 dots total, done one cycle after the last entry.
// Selects up to MAX_SPRITES line-covering sprites in OAM order; no backpressure, read port is combinational.
module oam_scanner #(
    parameter int MAX_SPRITES = 10,
    parameter int NUM_ENTRIES = 40
) (
    input  logic          clk,
    input  logic          rst,
    oam_scanner_if.master bus
);
    typedef enum logic [1:0] {IDLE, SCAN_POS, SCAN_ATTR, DONE} state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [3:0] row;
        logic [7:0] tile;
        logic [7:0] attr;
    } spr_t;

    localparam logic [3:0] MAX_CNT    = 4'(MAX_SPRITES);
    localparam logic [5:0] LAST_ENTRY = 6'(NUM_ENTRIES - 1);

    state_t     state_q, state_d;
    logic [5:0] entry_q, entry_d;
    logic [3:0] count_q, count_d;
    logic       pend_hit_q, pend_hit_d;
    logic [3:0] pend_diff_q, pend_diff_d;
    logic [7:0] pend_x_q, pend_x_d;
    logic       pend_tall_q, pend_tall_d;
    spr_t       buf_q [MAX_SPRITES];

    logic       wr_en;
    spr_t       wr_dat;
    logic [6:0] oam_addr;
    logic       busy;
    logic       done;

    // Vertical test in 9 bits so ly+16 never wraps against Y.
    logic [8:0] base9, y9, diff9, height9;
    logic       hit;
    logic [3:0] row_max, row;

    always_comb begin
        base9   = {1'b0, bus.ly} + 9'd16;
        y9      = {1'b0, bus.oam_data[7:0]};
        diff9   = base9 - y9;
        height9 = bus.obj_size ? 9'd16 : 9'd8;
        hit     = (base9 >= y9) && (diff9 < height9);
        row_max = pend_tall_q ? 4'd15 : 4'd7;
        row     = bus.oam_data[14] ? (row_max - pend_diff_q) : pend_diff_q;
    end

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        count_d     = count_q;
        pend_hit_d  = pend_hit_q;
        pend_diff_d = pend_diff_q;
        pend_x_d    = pend_x_q;
        pend_tall_d = pend_tall_q;
        wr_en       = 1'b0;
        wr_dat      = '0;
        oam_addr    = '0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            SCAN_POS: begin
                oam_addr    = {entry_q, 1'b0};
                busy        = 1'b1;
                pend_hit_d  = hit;
                pend_diff_d = diff9[3:0];
                pend_x_d    = bus.oam_data[15:8];
                pend_tall_d = bus.obj_size;
                state_d     = SCAN_ATTR;
            end
            SCAN_ATTR: begin
                oam_addr = {entry_q, 1'b1};
                busy     = 1'b1;
                if (pend_hit_q && bus.obj_ena && (count_q < MAX_CNT)) begin
                    wr_en   = 1'b1;
                    wr_dat  = '{x: pend_x_q, row: row,
                                tile: bus.oam_data[7:0], attr: bus.oam_data[15:8]};
                    count_d = count_q + 4'd1;
                end
                if (entry_q == LAST_ENTRY) begin
                    state_d = DONE;
                end else begin
                    entry_d = entry_q + 6'd1;
                    state_d = SCAN_POS;
                end
            end
            DONE:    done = 1'b1;
            default: ;
        endcase

        // A fresh start abandons whatever was in flight, including a pending write.
        if (bus.start) begin
            state_d = SCAN_POS;
            entry_d = '0;
            count_d = '0;
            wr_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            entry_q     <= '0;
            count_q     <= '0;
            pend_hit_q  <= 1'b0;
            pend_diff_q <= '0;
            pend_x_q    <= '0;
            pend_tall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            entry_q     <= entry_d;
            count_q     <= count_d;
            pend_hit_q  <= pend_hit_d;
            pend_diff_q <= pend_diff_d;
            pend_x_q    <= pend_x_d;
            pend_tall_q <= pend_tall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[count_q] <= wr_dat;
        end
    end

    spr_t rd_ent;

    always_comb begin
        bus.rd_valid = (bus.rd_idx < count_q);
        rd_ent       = bus.rd_valid ? buf_q[bus.rd_idx] : '0;
    end

    assign bus.rd_x     = rd_ent.x;
    assign bus.rd_row   = rd_ent.row;
    assign bus.rd_tile  = rd_ent.tile;
    assign bus.rd_attr  = rd_ent.attr;
    assign bus.oam_addr = oam_addr;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.count    = count_q;
endmodule

// File: doc/oam_scanner.md
Name: oam_scanner

Overview:
- Mode-2 (OAM scan) stage of the PPU, directly upstream of the draw-phase renderer and pixel fetcher.
- Walks all 40 OAM entries in 80 dots and selects up to 10 sprites whose vertical span covers the current line `ly`.
- Stores the selections in a 10-entry buffer. During draw, the renderer reads the buffer through an indexed read port to feed sprite fetches.

Parameters:
- MAX_SPRITES, 10, maximum number of sprites selected per line.
- NUM_ENTRIES, 40, number of OAM entries scanned.

Ports:
- clk  input  1  PPU dot clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a scan on the next cycle.
- ly  input  8  current scanline, stable for the whole scan.
- obj_size  input  1  LCDC.2; 0 = 8x8 sprites, 1 = 8x16 sprites.
- obj_ena  input  1  LCDC.1; 0 = scan runs but records nothing.
- oam_addr  output  7  OAM word address (16-bit words, 80 words).
- oam_data  input  16  OAM word data. OAM is clocked on ~clk, so data for the `oam_addr` driven in cycle t is valid at the posedge ending cycle t.
- busy  output  1  scan in progress.
- done  output  1  scan finished; buffer valid.
- count  output  4  number of sprites selected, 0..10.
- rd_idx  input  4  buffer read index.
- rd_valid  output  1  rd_idx < count.
- rd_x  output  8  OAM X byte of the selected entry.
- rd_row  output  4  sprite row to fetch (Y-flip applied), 0..15.
- rd_tile  output  8  tile index.
- rd_attr  output  8  attribute byte.

Behaviour:
- OAM word layout:
  - Entry n occupies words 2n and 2n+1.
  - Word 2n: [7:0] = Y, [15:8] = X.
  - Word 2n+1: [7:0] = tile, [15:8] = attr.
- FSM states: IDLE, SCAN_POS, SCAN_ATTR, DONE.
- Reset and rst: state = IDLE, entry = 0, count = 0, busy = 0, done = 0, oam_addr = 0. Buffer contents are don't-care, but rd_valid = 0.
- start in any state (including mid-scan) moves to SCAN_POS with entry = 0 and count = 0. rst has priority over start.
- SCAN_POS:
  - oam_addr = {entry, 0}.
  - Compute diff = {1'b0, ly} + 9'd16 − {1'b0, Y} in 9-bit arithmetic.
  - hit = (ly + 16 ≥ Y) and diff < height, where height = 16 if obj_size else 8.
  - Latch hit, diff[3:0] and X into pending registers; go to SCAN_ATTR.
- SCAN_ATTR:
  - oam_addr = {entry, 1}.
  - If pending hit and obj_ena and count < MAX_SPRITES: write {X, row, tile, attr} to buffer[count] and increment count.
  - row = diff if attr[6] = 0, else height − 1 − diff, truncated to 4 bits.
  - If entry = 39, go to DONE; otherwise increment entry and go to SCAN_POS.
- Hits beyond the 10th are ignored; scanning continues to entry 39 regardless.
- X = 0 and X ≥ 168 still consume a buffer slot. Selection order is OAM order.
- Timing:
  - start sampled in cycle 0.
  - Cycles 1..80 are scan cycles, with busy = 1.
  - DONE entered at cycle 81: done = 1, busy = 0.
  - DONE holds until the next start or rst; count is frozen.
- IDLE and DONE drive oam_addr = 0. OAM port muxing is the parent's responsibility.
- Read port is combinational from rd_idx.
  - rd_valid = (rd_idx < count).
  - When rd_valid = 0, rd_x, rd_row, rd_tile and rd_attr are driven 0.
  - Readable in any state; entries are valid as soon as they are written.
- ly and obj_size changes mid-scan: the new values are used for subsequent entries only. No protection is provided.

Test Plan:
- ly = 0, obj_size = 0, only entry 5 = {Y = 16, X = 20, tile = 7, attr = 0}, start → done exactly 81 cycles after start; count = 1; rd_idx = 0 gives x = 20, row = 0, tile = 7; rd_idx = 1 gives rd_valid = 0.
- Vertical boundaries, ly = 0, 8x8: Y = 9 hits with row 7; Y = 8 misses; Y = 17 misses. Switch to 8x16: Y = 1 hits with row 15; Y = 0 misses; Y = 17 misses.
- Y-flip, ly = 2, Y = 16, attr = 0x40: 8x8 gives row 5; 8x16 gives row 13.
- All 40 entries hit (Y = 16, X = entry index, ly = 0) → count = 10; rd_x for idx 0..9 = 0..9; entries 10..39 dropped; done still at cycle 81.
- obj_ena = 0 with 3 hitting entries → count = 0, done asserted normally.
- start re-pulsed at cycle 40 of a scan → count restarts from 0; done at cycle 81 after the second start. rst at cycle 30 → IDLE, count = 0, done = 0, and no done afterwards.
